// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the line-memory arbiter.
//   line_t / line_addr_t : memory line data and line address
//   arb_state_t          : IDLE (sample and grant), BUSY (memory handshake),
//                          RESP (one-cycle ack to the winner)
//   req_id_t             : requester identity, also the round-robin pointer value
//   sat_inc32            : saturating increment used by the optional statistics
package mem_arb_pkg;

  localparam int MEM_LINE_W      = 128;
  localparam int MEM_LINE_ADDR_W = 10;

  typedef logic [MEM_LINE_W-1:0]      line_t;
  typedef logic [MEM_LINE_ADDR_W-1:0] line_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (&value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick: combinational two-way round-robin picker.
//   req[0]      in  I-cache request
//   req[1]      in  D-cache request
//   rr_ptr      in  side that wins when both request
//   grant_valid out at least one request present
//   grant_id    out winning side (only meaningful with grant_valid)
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic    [1:0] req,
  input  req_id_t       rr_ptr,
  output logic          grant_valid,
  output req_id_t       grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = REQ_IC;
    if (req == 2'b11) begin
      grant_id = rr_ptr;
    end else if (req[1]) begin
      grant_id = REQ_DC;
    end
  end

endmodule

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: shares one line-wide main memory between the I-cache
// refill port and the D-cache refill/writeback port, one transaction at a time
// with round-robin priority.
//   clock, reset (async, active low)
//   ic_req/ic_addr -> ic_ack/ic_rdata       : I-cache read port
//   dc_req/dc_we/dc_addr/dc_wdata -> dc_ack/dc_rdata : D-cache read/write port
//   mem_req/mem_we/mem_addr/mem_wdata <- mem_ready/mem_rdata : memory handshake
// Optional build macro MEM_ARB_STATS_EN adds the saturating 32-bit outputs
// ic_grants, dc_grants and wait_cycles.
module mem_line_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_W      = MEM_LINE_W,
  parameter int LINE_ADDR_W = MEM_LINE_ADDR_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ic_req,
  input  logic [LINE_ADDR_W-1:0] ic_addr,
  output logic                   ic_ack,
  output logic [LINE_W-1:0]      ic_rdata,
  input  logic                   dc_req,
  input  logic                   dc_we,
  input  logic [LINE_ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0]      dc_wdata,
  output logic                   dc_ack,
  output logic [LINE_W-1:0]      dc_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [LINE_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]      mem_wdata,
  input  logic                   mem_ready,
  input  logic [LINE_W-1:0]      mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]            ic_grants,
  output logic [31:0]            dc_grants,
  output logic [31:0]            wait_cycles
`endif
);

  arb_state_t             state_reg, state_next;
  req_id_t                rr_ptr_reg;
  req_id_t                win_id_reg;
  logic                   we_reg;
  logic [LINE_ADDR_W-1:0] addr_reg;
  logic [LINE_W-1:0]      wdata_reg;
  logic [LINE_W-1:0]      rdata_reg;

  logic [1:0]             req_vec;
  logic                   grant_valid;
  req_id_t                grant_id;

  assign req_vec = {dc_req, ic_req};

  mem_arb_rr_pick u_pick (
    .req         (req_vec),
    .rr_ptr      (rr_ptr_reg),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; requests are only looked at in IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = BUSY;
      BUSY:    if (mem_ready)   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, read-data capture and round-robin pointer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_reg <= REQ_IC;
      win_id_reg <= REQ_IC;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
    end else begin
      if (state_reg == IDLE && grant_valid) begin
        win_id_reg <= grant_id;
        if (grant_id == REQ_DC) begin
          we_reg    <= dc_we;
          addr_reg  <= dc_addr;
          wdata_reg <= dc_we ? dc_wdata : '0;
        end else begin
          // I-cache traffic is read-only
          we_reg    <= 1'b0;
          addr_reg  <= ic_addr;
          wdata_reg <= '0;
        end
      end
      if (state_reg == BUSY && mem_ready) begin
        rdata_reg <= mem_rdata;
      end
      if (state_reg == RESP) begin
        rr_ptr_reg <= (win_id_reg == REQ_IC) ? REQ_DC : REQ_IC;
      end
    end
  end

  // Outputs decode straight from the state register, so an asynchronous
  // reset drops mem_req immediately.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ic_ack    = 1'b0;
    dc_ack    = 1'b0;
    case (state_reg)
      BUSY: begin
        mem_req   = 1'b1;
        mem_we    = we_reg;
        mem_addr  = addr_reg;
        mem_wdata = wdata_reg;
      end
      RESP: begin
        ic_ack = (win_id_reg == REQ_IC);
        dc_ack = (win_id_reg == REQ_DC);
      end
      default: ;
    endcase
  end

  // Both ports see the captured line; the ack is what qualifies it.
  assign ic_rdata = rdata_reg;
  assign dc_rdata = rdata_reg;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] ic_grants_reg, dc_grants_reg, wait_cycles_reg;
  logic [1:0]  waiting;

  // A requester waits whenever its req is high and it is not the side
  // currently owning a BUSY/RESP transaction (IDLE serves nobody yet).
  for (genvar gi = 0; gi < 2; gi++) begin : g_wait
    assign waiting[gi] = req_vec[gi] &&
                         !((state_reg != IDLE) && (win_id_reg == req_id_t'(gi)));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ic_grants_reg   <= '0;
      dc_grants_reg   <= '0;
      wait_cycles_reg <= '0;
    end else begin
      if (state_reg == RESP && win_id_reg == REQ_IC) ic_grants_reg <= sat_inc32(ic_grants_reg);
      if (state_reg == RESP && win_id_reg == REQ_DC) dc_grants_reg <= sat_inc32(dc_grants_reg);
      if (|waiting) wait_cycles_reg <= sat_inc32(wait_cycles_reg);
    end
  end

  assign ic_grants   = ic_grants_reg;
  assign dc_grants   = dc_grants_reg;
  assign wait_cycles = wait_cycles_reg;
`endif

endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb_mem_line_arbiter: directed table, hand-written corner sequences and a
// randomized run checked against a transaction-level model of the arbiter.
module tb_mem_line_arbiter;
  import mem_arb_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ic_req = 1'b0;
  line_addr_t ic_addr = '0;
  logic       ic_ack;
  line_t      ic_rdata;
  logic       dc_req = 1'b0;
  logic       dc_we = 1'b0;
  line_addr_t dc_addr = '0;
  line_t      dc_wdata = '0;
  logic       dc_ack;
  line_t      dc_rdata;
  logic       mem_req;
  logic       mem_we;
  line_addr_t mem_addr;
  line_t      mem_wdata;
  logic       mem_ready = 1'b0;
  line_t      mem_rdata = '0;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] ic_grants, dc_grants, wait_cycles;
`endif

  mem_line_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_ack    (ic_ack),
    .ic_rdata  (ic_rdata),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_ack    (dc_ack),
    .dc_rdata  (dc_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .ic_grants   (ic_grants),
    .dc_grants   (dc_grants),
    .wait_cycles (wait_cycles)
`endif
  );

  always #5 clock = ~clock;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int prio      = 0;   // model: 0 -> I-cache preferred, 1 -> D-cache preferred

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0b required=%0b", name, act, exp);
  endtask

  task automatic chk_addr(input string name, input line_addr_t act, input line_addr_t exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic chk_line(input string name, input line_t act, input line_t exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  function automatic line_t rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Waits for the grant, checks the memory request, answers after lat
  // BUSY cycles with rd, then checks the one-cycle ack to the expected side.
  task automatic serve(input int lat, input line_t rd, input int exp_id,
                       input line_addr_t ea, input logic ewe, input line_t ewd,
                       input bit cwd, input bit drop, input string tag);
    bit seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      if (mem_req) begin
        seen = 1;
        break;
      end
    end
    chk_bit({tag, "_grant"}, seen, 1'b1);
    if (!seen) return;
    chk_addr({tag, "_mem_addr"}, mem_addr, ea);
    chk_bit({tag, "_mem_we"}, mem_we, ewe);
    if (cwd) chk_line({tag, "_mem_wdata"}, mem_wdata, ewd);
    for (int i = 1; i < lat; i++) @(negedge clock);
    chk_bit({tag, "_req_held"}, mem_req, 1'b1);
    mem_ready = 1'b1;
    mem_rdata = rd;
    @(negedge clock);
    mem_ready = 1'b0;
    mem_rdata = rand_line();
    chk_bit({tag, "_ic_ack"}, ic_ack, exp_id == 0);
    chk_bit({tag, "_dc_ack"}, dc_ack, exp_id == 1);
    if (!ewe) chk_line({tag, "_rdata"}, (exp_id == 0) ? ic_rdata : dc_rdata, rd);
    chk_bit({tag, "_resp_no_req"}, mem_req, 1'b0);
    @(posedge clock);
    #1;
    if (drop) begin
      if (exp_id == 0) ic_req = 1'b0;
      else dc_req = 1'b0;
    end
    @(negedge clock);
    chk_bit({tag, "_ack_one_cycle"}, ic_ack | dc_ack, 1'b0);
    chk_bit({tag, "_idle_gap"}, mem_req, 1'b0);
    prio = 1 - exp_id;
  endtask

  typedef struct {
    bit         set_ic;
    bit         set_dc;
    line_addr_t ic_a;
    line_addr_t dc_a;
    bit         dc_w;
    line_t      dc_d;
    int         lat;
    line_t      rd;
    int         exp_id;
    line_addr_t exp_addr;
    bit         exp_we;
    line_t      exp_wdata;
    bit         chk_wd;
  } vec_t;

  vec_t vecs[7];

  // Random-phase model state
  line_t      mem_model [1024];
  bit         ic_pend, dc_pend, dc_w_m, in_txn, ack_due, stray, txn_we;
  line_addr_t ic_a_m, dc_a_m, exp_a;
  line_t      dc_d_m, exp_rd;
  int         txn_id, lat, idle_wait, n_txn, exp_id;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 10'h005, 10'h000, 1'b0, 128'h0, 3,
                128'h00000017_00000016_00000015_00000014,
                0, 10'h005, 1'b0, 128'h0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 10'h000, 10'h3FF, 1'b1, {16{8'hA5}}, 1,
                128'h0, 1, 10'h3FF, 1'b1, {16{8'hA5}}, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 10'h010, 10'h020, 1'b0, 128'h0, 2,
                128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 0, 10'h010, 1'b0, 128'h0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 128'h0, 1,
                128'h11112222_33334444_55556666_77778888, 1, 10'h020, 1'b0, 128'h0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 10'h033, 10'h000, 1'b0, 128'h0, 1,
                128'hF0F0F0F0_0F0F0F0F_AAAA5555_5555AAAA, 0, 10'h033, 1'b0, 128'h0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 10'h044, 10'h055, 1'b1, 128'hCAFE0000_BEEF1111_12345678_9ABCDEF0, 2,
                128'h0, 1, 10'h055, 1'b1, 128'hCAFE0000_BEEF1111_12345678_9ABCDEF0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 128'h0, 4,
                128'h0BADF00D_00000001_00000002_00000003, 0, 10'h044, 1'b0, 128'h0, 1'b1};

    // ---------------- reset state ----------------
    @(negedge clock);
    @(negedge clock);
    chk_bit("rst_mem_req", mem_req, 1'b0);
    chk_bit("rst_mem_we", mem_we, 1'b0);
    chk_addr("rst_mem_addr", mem_addr, '0);
    chk_line("rst_mem_wdata", mem_wdata, '0);
    chk_bit("rst_ic_ack", ic_ack, 1'b0);
    chk_bit("rst_dc_ack", dc_ack, 1'b0);
    chk_line("rst_rdata", ic_rdata, '0);
    reset = 1'b1;
    prio  = 0;

    // ---------------- directed table ----------------
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].set_ic) begin
        ic_req  = 1'b1;
        ic_addr = vecs[v].ic_a;
      end
      if (vecs[v].set_dc) begin
        dc_req   = 1'b1;
        dc_we    = vecs[v].dc_w;
        dc_addr  = vecs[v].dc_a;
        dc_wdata = vecs[v].dc_d;
      end
      serve(vecs[v].lat, vecs[v].rd, vecs[v].exp_id, vecs[v].exp_addr,
            vecs[v].exp_we, vecs[v].exp_wdata, vecs[v].chk_wd, 1'b1,
            $sformatf("vec%0d", v));
    end

    // ---------------- alternation with both requesters held ----------------
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 10'h111;
    @(posedge clock);
    #1;
    ic_req = 1'b1; ic_addr = 10'h222;
    serve(2, rand_line(), 1, 10'h111, 1'b0, '0, 1'b0, 1'b0, "alt1");
    serve(1, rand_line(), 0, 10'h222, 1'b0, '0, 1'b1, 1'b0, "alt2");
    serve(3, rand_line(), 1, 10'h111, 1'b0, '0, 1'b0, 1'b0, "alt3");
    serve(1, rand_line(), 0, 10'h222, 1'b0, '0, 1'b1, 1'b1, "alt4");
    serve(1, rand_line(), 1, 10'h111, 1'b0, '0, 1'b0, 1'b1, "alt5");

    // ---------------- reset in the middle of BUSY ----------------
    ic_req = 1'b1; ic_addr = 10'h0AA;
    begin
      bit seen = 0;
      for (int n = 0; n < 8; n++) begin
        @(negedge clock);
        if (mem_req) begin
          seen = 1;
          break;
        end
      end
      chk_bit("rstbusy_grant", seen, 1'b1);
    end
    #2 reset = 1'b0;
    #1;
    chk_bit("rstbusy_async_req_drop", mem_req, 1'b0);
    @(negedge clock);
    chk_bit("rstbusy_no_ic_ack", ic_ack, 1'b0);
    chk_bit("rstbusy_no_dc_ack", dc_ack, 1'b0);
    chk_line("rstbusy_rdata_clear", dc_rdata, '0);
    reset = 1'b1;
    prio  = 0;
    @(posedge clock);
    #1;
    chk_bit("rstbusy_regrant", mem_req, 1'b1);
    chk_addr("rstbusy_regrant_addr", mem_addr, 10'h0AA);
    serve(1, 128'h5, 0, 10'h0AA, 1'b0, '0, 1'b1, 1'b1, "rstbusy_resume");

`ifdef MEM_ARB_STATS_EN
    // ---------------- statistics: simultaneous pair, 2-cycle memory ----------------
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    prio  = 0;
    @(negedge clock);
    ic_req = 1'b1; ic_addr = 10'h001;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 10'h002;
    serve(2, rand_line(), 0, 10'h001, 1'b0, '0, 1'b1, 1'b1, "stat_ic");
    serve(2, rand_line(), 1, 10'h002, 1'b0, '0, 1'b0, 1'b1, "stat_dc");
    chk32("stat_ic_grants", ic_grants, 32'd1);
    chk32("stat_dc_grants", dc_grants, 32'd1);
    chk32("stat_wait_cycles", wait_cycles, 32'd5);
`endif

    // ---------------- randomized run against the transaction model ----------------
    ic_req = 1'b0; dc_req = 1'b0; mem_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    prio = 0;
    for (int i = 0; i < 1024; i++) mem_model[i] = rand_line();
    ic_pend = 0; dc_pend = 0; in_txn = 0; ack_due = 0; stray = 0;
    idle_wait = 0; n_txn = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clock);
      if (stray) begin
        mem_ready = 1'b0;
        stray = 0;
      end
      if (ack_due) begin
        chk_bit("rnd_ic_ack", ic_ack, txn_id == 0);
        chk_bit("rnd_dc_ack", dc_ack, txn_id == 1);
        if (!txn_we) chk_line("rnd_rdata", (txn_id == 0) ? ic_rdata : dc_rdata, exp_rd);
        mem_ready = 1'b0;
        mem_rdata = rand_line();
        prio = 1 - txn_id;
        if (txn_id == 0) ic_pend = 0;
        else dc_pend = 0;
        in_txn = 0;
        ack_due = 0;
        n_txn++;
      end else begin
        chk_bit("rnd_no_ack", ic_ack | dc_ack, 1'b0);
      end

      if (!in_txn) begin
        if (mem_req) begin
          chk_bit("rnd_grant_has_req", ic_pend | dc_pend, 1'b1);
          if (ic_pend && dc_pend) exp_id = prio;
          else exp_id = dc_pend ? 1 : 0;
          txn_id = exp_id;
          txn_we = (exp_id == 1) && dc_w_m;
          exp_a  = (exp_id == 1) ? dc_a_m : ic_a_m;
          chk_addr("rnd_mem_addr", mem_addr, exp_a);
          chk_bit("rnd_mem_we", mem_we, txn_we);
          if (exp_id == 0) chk_line("rnd_mem_wdata_ic", mem_wdata, '0);
          else if (txn_we) chk_line("rnd_mem_wdata_dc", mem_wdata, dc_d_m);
          exp_rd = mem_model[exp_a];
          in_txn = 1;
          lat = $urandom_range(1, 4);
          idle_wait = 0;
        end else begin
          chk_bit("rnd_idle_outputs_zero",
                  (mem_we == 1'b0) && (mem_addr == '0) && (mem_wdata == '0), 1'b1);
          if (ic_pend || dc_pend) begin
            idle_wait++;
            chk_bit("rnd_grant_latency", idle_wait <= 3, 1'b1);
          end
        end
      end

      if (in_txn && !ack_due) begin
        chk_bit("rnd_req_held", mem_req, 1'b1);
        lat--;
        if (lat == 0) begin
          mem_ready = 1'b1;
          if (txn_we) mem_model[mem_addr] = mem_wdata;
          else mem_rdata = mem_model[mem_addr];
          ack_due = 1;
        end
      end else if (!in_txn && $urandom_range(0, 7) == 0) begin
        // mem_ready outside BUSY must be ignored
        mem_ready = 1'b1;
        mem_rdata = rand_line();
        stray = 1;
      end

      if (!ic_pend && $urandom_range(0, 2) == 0) begin
        ic_pend = 1;
        ic_a_m  = 10'($urandom);
      end
      if (!dc_pend && $urandom_range(0, 2) == 0) begin
        dc_pend = 1;
        dc_a_m  = 10'($urandom_range(0, 31));
        dc_w_m  = 1'($urandom);
        dc_d_m  = rand_line();
      end
      ic_req   = ic_pend;
      ic_addr  = ic_a_m;
      dc_req   = dc_pend;
      dc_addr  = dc_a_m;
      dc_we    = dc_w_m;
      dc_wdata = dc_d_m;
    end
    chk_bit("rnd_enough_transactions", n_txn > 40, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Shares the single 128-bit-line main memory between the I-cache refill port and the D-cache refill/writeback port.
- Sits between both cache controllers and the main memory inside the memory subsystem.
- Performs one line transaction at a time and uses round-robin priority so neither cache starves.
- Registers each request at grant time, drives a req/ready handshake to memory, and returns a one-cycle ack with read data to the winner.

Parameters:
- LINE_W, 128, memory line width in bits (four 32-bit words).
- LINE_ADDR_W, 10, line address width (1024 lines).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- ic_req  in  1  I-cache request; held high until ic_ack.
- ic_addr  in  LINE_ADDR_W  I-cache line address; stable while ic_req is high.
- ic_ack  out  1  one-cycle completion pulse to the I-cache.
- ic_rdata  out  LINE_W  line data; valid only when ic_ack is high.
- dc_req  in  1  D-cache request; held high until dc_ack.
- dc_we  in  1  1 = line write, 0 = line read.
- dc_addr  in  LINE_ADDR_W  D-cache line address.
- dc_wdata  in  LINE_W  writeback data; valid when dc_we is 1.
- dc_ack  out  1  one-cycle completion pulse to the D-cache.
- dc_rdata  out  LINE_W  line data; valid only when dc_ack is high and the access was a read.
- mem_req  out  1  memory request; held high until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  LINE_ADDR_W  memory line address.
- mem_wdata  out  LINE_W  memory write data.
- mem_ready  in  1  memory completion pulse; mem_rdata is valid in the same cycle.
- mem_rdata  in  LINE_W  memory read data.

Behaviour:
- FSM states:
  - IDLE: if any request is pending, pick a winner, latch winner id, we, addr and wdata, then go to BUSY. With no request, stay in IDLE.
  - BUSY: mem_req = 1 and mem_we/addr/wdata come from the latched registers. On mem_ready, capture mem_rdata into rdata_q and go to RESP. Without mem_ready, stay in BUSY indefinitely; there is no timeout.
  - RESP: assert the ack of the winner only. Update rr_ptr to point to the other requester. Go to IDLE unconditionally.
- Arbitration:
  - rr_ptr = 0 means the I-cache has priority; rr_ptr = 1 means the D-cache has priority.
  - A single requester always wins.
  - When both request, the side named by rr_ptr wins.
  - rr_ptr changes only in RESP.
- Requests seen during BUSY or RESP are not sampled. They stay pending because requesters hold req until ack.
- I-cache accesses are always reads: latched we = 0 and wdata = 0.
- ic_rdata and dc_rdata both drive rdata_q. Only the ack qualifies the data.
- mem_we, mem_addr and mem_wdata are 0 whenever mem_req = 0.
- Latency:
  - Requester req sampled in IDLE at edge N gives mem_req high in cycle N+1.
  - mem_ready in the cycle at edge M gives ack high in cycle M+1.
  - Minimum round trip is 2 cycles from grant edge to ack, plus 1 IDLE cycle before the next grant.
- Requester rule: drop req, or present a new request, in the cycle after ack. IDLE following RESP samples req fresh.
- Reset values, applied immediately when reset = 0:
  - state = IDLE, rr_ptr = 0.
  - mem_req/we/addr/wdata = 0.
  - ic_ack = dc_ack = 0, rdata = 0.
- Reset asserted mid-BUSY abandons the transaction. No ack is issued, and the memory sees mem_req drop asynchronously.
- mem_ready received outside BUSY is ignored.

Optional Feature:
- MEM_ARB_STATS_EN. When defined, the block adds these outputs:
  - ic_grants, 32-bit: counts RESP cycles for the I-cache.
  - dc_grants, 32-bit: counts RESP cycles for the D-cache.
  - wait_cycles, 32-bit: counts cycles where a request is pending but not granted, i.e. a requester's req is high and the FSM is not serving it.
- The counters saturate at all-ones and reset to 0.
- When undefined, these ports and counters do not exist, and the rest of the behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - typedefs line_t (LINE_W bits) and line_addr_t.
  - enum arb_state_t {IDLE, BUSY, RESP}.
  - enum req_id_t {REQ_IC = 0, REQ_DC = 1}.
- Sub-module mem_arb_rr_pick: combinational 2-way round-robin picker. Inputs are req[1:0] and rr_ptr; outputs are grant_valid and grant_id.

Test Plan:
- Lone I-cache read, addr 0x005, memory mem_ready after 3 cycles with data 0x00000017_00000016_00000015_00000014 -> mem_addr = 0x005, mem_we = 0, ic_ack for exactly one cycle with that data, dc_ack stays 0.
- D-cache write, addr 0x3FF, wdata all 0xA5 -> mem_we = 1, mem_wdata = 0xA5..A5, dc_ack pulse, rr_ptr ends at 0.
- ic_req and dc_req asserted in the same cycle, both held -> I-cache is served first, then the D-cache. A second simultaneous pair after both acks -> D-cache first.
- dc_req held continuously over 4 transactions while ic_req rises during the first -> grants alternate DC, IC, DC, IC. No back-to-back win for either side while both are pending.
- reset driven to 0 while in BUSY -> mem_req falls in the same cycle, no ack; after release, the held ic_req is granted with mem_req in the second cycle after release.
- With MEM_ARB_STATS_EN defined, rerun the simultaneous-request case with 2-cycle memory latency -> ic_grants = 1, dc_grants = 1, wait_cycles = 5 for the D-side (IDLE grant edge, 2 BUSY, RESP, IDLE).
